// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
// Module      : life_engine
// Description : Game of Life generation engine. It holds a ROWS x COLS grid
//               and computes one generation for each accepted step request.
//               The next generation is built one row per cycle into a shadow
//               buffer, then committed in a single cycle. Birth and survive
//               rule masks are latched at step acceptance. Edges are either
//               toroidal (WRAP=1) or dead (WRAP=0).
//
// Ports       : clk          - system clock
//               rst_n        - asynchronous active-low reset
//               load         - load load_cells into the grid (IDLE only)
//               load_cells   - pattern to load, cell (r,c) = bit r*COLS+c
//               step         - request one generation (IDLE only)
//               birth_mask   - bit n: dead cell with n neighbours is born
//               survive_mask - bit n: live cell with n neighbours survives
//               busy         - high while COMPUTE or COMMIT
//               done         - one-cycle pulse when a new generation is visible
//               cells_q      - current grid
//               gen_count    - generations since last load/reset
//               stable       - last committed generation equalled predecessor
//               extinct      - grid is all zero
//
// Revision    : 1.0 - initial release
// ============================================================================
module life_engine #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int WRAP  = 1,
    parameter int GEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] load_cells,
    input  logic                 step,
    input  logic [8:0]           birth_mask,
    input  logic [8:0]           survive_mask,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] cells_q,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 extinct
);

    localparam int N  = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [N-1:0]     next_q, next_d;
    logic [N-1:0]     cells_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [8:0]       birth_q, birth_d;
    logic [8:0]       surv_q, surv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stable_q, stable_d;
    logic             extinct_q, extinct_d;

    // ------------------------------------------------------------------------
    // Neighbourhood of the row currently being computed
    // ------------------------------------------------------------------------
    logic [RW-1:0]   w_row_up, w_row_dn;
    logic [COLS-1:0] w_up, w_mid, w_dn, w_next_row;
    logic [COLS+1:0] w_pad_up, w_pad_mid, w_pad_dn;

    // Extend a row by one column on each side; the extra columns hold the
    // wrapped-around cells or zero for dead borders. Bit 0 is column -1.
    function automatic logic [COLS+1:0] pad_row(input logic [COLS-1:0] row);
        logic l_edge;
        logic r_edge;
        l_edge  = (WRAP != 0) ? row[COLS-1] : 1'b0;
        r_edge  = (WRAP != 0) ? row[0]      : 1'b0;
        pad_row = {r_edge, row, l_edge};
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        popcount8 = cnt;
    endfunction

    always_comb begin
        w_row_up = (row_q == '0) ? LAST_ROW : row_q - RW'(1);
        w_row_dn = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
        w_mid    = cells_q[row_q * COLS +: COLS];
        w_up     = cells_q[w_row_up * COLS +: COLS];
        w_dn     = cells_q[w_row_dn * COLS +: COLS];
        // Without wrap the rows beyond the top and bottom edges are dead.
        if (WRAP == 0) begin
            if (row_q == '0)      w_up = '0;
            if (row_q == LAST_ROW) w_dn = '0;
        end
        w_pad_up  = pad_row(w_up);
        w_pad_mid = pad_row(w_mid);
        w_pad_dn  = pad_row(w_dn);
    end

    // Column c sits at padded index c+1, so its neighbours span c..c+2.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [7:0] w_nb;
        logic [3:0] w_cnt;
        assign w_nb  = {w_pad_up[c+2:c], w_pad_mid[c+2], w_pad_mid[c],
                        w_pad_dn[c+2:c]};
        assign w_cnt = popcount8(w_nb);
        assign w_next_row[c] = w_mid[c] ? surv_q[w_cnt] : birth_q[w_cnt];
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        next_d    = next_q;
        cells_d   = cells_q;
        gen_d     = gen_q;
        birth_d   = birth_q;
        surv_d    = surv_q;
        stable_d  = stable_q;
        extinct_d = extinct_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // load has priority; a simultaneous step is discarded.
                if (load) begin
                    cells_d   = load_cells;
                    gen_d     = '0;
                    stable_d  = 1'b0;
                    extinct_d = (load_cells == '0);
                end else if (step) begin
                    birth_d = birth_mask;
                    surv_d  = survive_mask;
                    row_d   = '0;
                    state_d = S_COMPUTE;
                    busy_d  = 1'b1;
                end
            end
            S_COMPUTE: begin
                busy_d = 1'b1;
                next_d[row_q * COLS +: COLS] = w_next_row;
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = S_COMMIT;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            S_COMMIT: begin
                cells_d   = next_q;
                stable_d  = (next_q == cells_q);
                extinct_d = (next_q == '0);
                gen_d     = gen_q + GEN_W'(1);
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            next_q    <= '0;
            cells_q   <= '0;
            gen_q     <= '0;
            birth_q   <= '0;
            surv_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            next_q    <= next_d;
            cells_q   <= cells_d;
            gen_q     <= gen_d;
            birth_q   <= birth_d;
            surv_q    <= surv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign gen_count = gen_q;
    assign stable    = stable_q;
    assign extinct   = extinct_q;

endmodule
`default_nettype wire
